des_key_loader: RTL and testbench
=================================

# des_key_loader

Assembles the Triple-DES key set from the byte stream delivered by the I2C slave receive path. It shifts incoming bytes MSB-first into 64-bit keys and publishes each completed key with a one-cycle enable strobe and a key index. The key-holding registers downstream latch `key_out` when their enable is asserted. The block sits between the I2C byte interface and the K1/K2/K3 key registers, and owns sequencing of a key-load transaction.

## Interface
- `NUM_KEYS`, default 3: keys per load transaction; legal values 1..3.
- `clk` input 1: system clock; all state changes on the rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `load_start` input 1: one-cycle pulse; begins a new key-load transaction.
- `byte_in` input 8: received data byte.
- `byte_valid` input 1: one-cycle pulse; `byte_in` is valid this cycle.
- `key_out` output 64: most recently completed key.
- `key_sel` output 2: index of the key on `key_out` (0 = K1, 1 = K2, 2 = K3).
- `key_enable` output 1: one-cycle pulse; `key_out`/`key_sel` are to be latched.
- `keys_ready` output 1: level; all `NUM_KEYS` keys loaded in the current transaction.
- `busy` output 1: level; transaction in progress (COLLECT state).
- `parity_err` output 1: level, sticky; parity failure in the current transaction.

## Operation
- Reset values:
  - `key_out` = 0, `key_sel` = 0.
  - `key_enable`, `keys_ready`, `busy`, `parity_err` = 0.
  - State = IDLE; byte counter = 0; key index = 0; shift register = 0.
- States:
  - IDLE: waiting for a transaction.
  - COLLECT: accepting key bytes.
  - DONE: all keys loaded.
  - ERROR: parity failure (parity build only).
- IDLE:
  - `byte_valid` is ignored.
  - `load_start` → COLLECT; clears byte counter, key index, `keys_ready`, `parity_err`.
- COLLECT:
  - Each `byte_valid` shifts `byte_in` into the low byte of the shift register (first byte ends up in bits 63:56) and increments the 3-bit byte counter.
  - On the 8th byte (counter wraps 7→0), the next edge does all of the following:
    - loads `key_out` = {shift[55:0], byte_in};
    - sets `key_sel` = key index;
    - pulses `key_enable`;
    - increments the key index.
  - When the completed key has index `NUM_KEYS`-1 → DONE, `keys_ready` = 1. Otherwise stay in COLLECT.
- DONE:
  - `byte_valid` is ignored.
  - `keys_ready` holds until the next `load_start` (→ COLLECT, `keys_ready` cleared).
- `load_start` in any state restarts the transaction.
  - A partial key is discarded; no `key_enable` is issued for it.
  - `key_out` keeps its last published value.
- `load_start` and `byte_valid` in the same cycle: `load_start` wins and the byte is dropped.
- `busy` = 1 exactly while in COLLECT.

## Timing
- `key_enable` is asserted in the cycle after the edge that samples the 8th `byte_valid` of a key. Latency is 1 cycle.
- `key_out` and `key_sel` change only on the same edge that raises `key_enable`, and stay stable until the next publish.
- Back-to-back `byte_valid` on every cycle is supported; there is no stall.
- The byte following a key's 8th byte may arrive in the very next cycle, including the `key_enable` cycle. It is accepted as byte 0 of the next key.
- `n_rst` asserted mid-transaction returns all outputs to reset values asynchronously.

## Configuration
- `DES_KEY_PARITY_CHECK_EN` defined:
  - Each accepted byte is checked for odd parity (DES convention).
  - An even-weight byte sets an internal flag for the current key.
  - When that key completes:
    - no `key_enable` is pulsed;
    - `key_out` is unchanged;
    - `parity_err` = 1;
    - state → ERROR.
  - ERROR ignores `byte_valid`; only `load_start` (→ COLLECT, flag cleared) or reset exits.
- `DES_KEY_PARITY_CHECK_EN` undefined:
  - No check is performed; `parity_err` is tied to 0.
  - The ERROR state is not built.

## Structure
- Shared package `des_pkg`:
  - state enum `key_load_state_t` (IDLE, COLLECT, DONE, ERROR);
  - `DES_KEY_BYTES` = 8;
  - `DES_KEY_W` = 64;
  - key index type `key_idx_t` (2 bits).
- One natural sub-module, `des_byte_parity`: combinational odd-parity check of one byte, reused by the data path check. The FSM, counters and shift register stay in the top.

## Test plan
- Full load, `NUM_KEYS` = 3:
  - Stimulus: `load_start`, then 24 spaced bytes forming K1 = 0x0123456789ABCDEF, K2 = 0x23456789ABCDEF01, K3 = 0x456789ABCDEF0123.
  - Response: three `key_enable` pulses, each one cycle after the 8th byte of its key, with `key_sel` 0/1/2 and `key_out` equal to each key.
  - `busy` high throughout; `keys_ready` = 1 after the third pulse; `busy` = 0 in DONE.
- Back-to-back bytes: the same 24 bytes on consecutive cycles → same three pulses at cycles 9, 17 and 25 after the first byte; no bytes lost.
- Restart mid-key:
  - Stimulus: `load_start`, 5 bytes, `load_start` asserted together with `byte_valid` (0xAA), then 8 bytes of K1.
  - Response: a single `key_enable` with `key_sel` = 0 and `key_out` = 0x0123456789ABCDEF; the 0xAA byte is dropped.
- Idle/DONE ignore bytes: `byte_valid` pulses before `load_start` and after `keys_ready` → no `key_enable`; `key_out` unchanged.
- Parity (`DES_KEY_PARITY_CHECK_EN`):
  - Stimulus: K1 with its 3rd byte = 0x00.
  - Response: no `key_enable`; `parity_err` = 1; further bytes ignored.
  - Then `load_start` with a valid K1 → `parity_err` cleared, normal publish.
- Async reset: assert `n_rst` after 4 bytes → all outputs 0 immediately; after release, a fresh full load behaves as in the full-load test.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: shared types and sizes for the Triple-DES key loader.
package des_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DONE, ERROR} key_load_state_t;
    localparam int DES_KEY_BYTES = 8;
    localparam int DES_KEY_W = 64;
    typedef logic [1:0] key_idx_t;
endpackage

// File: rtl/des_byte_parity.sv
// des_byte_parity: combinational odd-parity check of one byte (DES key convention).
module des_byte_parity (
    input  logic [7:0] data_i,
    output logic       odd_o
);
    assign odd_o = ^data_i;
endmodule

// File: rtl/des_key_loader.sv
// des_key_loader: shifts I2C bytes into 64-bit DES keys and publishes K1..K3 with a strobe.
// Optional DES_KEY_PARITY_CHECK_EN rejects keys holding an even-weight byte.
module des_key_loader
    import des_pkg::*;
#(
    parameter int NUM_KEYS = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 load_start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic [DES_KEY_W-1:0] key_out,
    output logic [1:0]           key_sel,
    output logic                 key_enable,
    output logic                 keys_ready,
    output logic                 busy,
    output logic                 parity_err
);
    key_load_state_t      state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    key_idx_t             idx_q, idx_d;
    logic [DES_KEY_W-1:0] shift_q, shift_d;
    logic [DES_KEY_W-1:0] key_q, key_d;
    key_idx_t             sel_q, sel_d;
    logic                 en_q, en_d;
    logic                 ready_q, ready_d;
    logic [DES_KEY_W-1:0] shift_next;
    logic                 last_byte;
    logic                 key_bad;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic perr_q, perr_d;
    logic pflag_q, pflag_d;
    logic byte_odd;

    des_byte_parity u_parity (
        .data_i(byte_in),
        .odd_o (byte_odd)
    );

    assign key_bad    = pflag_q | ~byte_odd;
    assign parity_err = perr_q;
`else
    assign key_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign shift_next = {shift_q[DES_KEY_W-9:0], byte_in};
    assign last_byte  = cnt_q == 3'(DES_KEY_BYTES - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        key_d   = key_q;
        sel_d   = sel_q;
        en_d    = 1'b0;
        ready_d = ready_q;
`ifdef DES_KEY_PARITY_CHECK_EN
        perr_d  = perr_q;
        pflag_d = pflag_q;
`endif
        // A restart beats a coincident byte, which is simply dropped.
        if (load_start) begin
            state_d = COLLECT;
            cnt_d   = '0;
            idx_d   = '0;
            ready_d = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
            perr_d  = 1'b0;
            pflag_d = 1'b0;
`endif
        end else if (state_q == COLLECT && byte_valid) begin
            shift_d = shift_next;
            cnt_d   = cnt_q + 3'd1;
`ifdef DES_KEY_PARITY_CHECK_EN
            pflag_d = key_bad;
`endif
            if (last_byte && key_bad) begin
`ifdef DES_KEY_PARITY_CHECK_EN
                state_d = ERROR;
                perr_d  = 1'b1;
                pflag_d = 1'b0;
`endif
            end else if (last_byte) begin
                key_d = shift_next;
                sel_d = idx_q;
                en_d  = 1'b1;
                idx_d = idx_q + 2'd1;
                if (idx_q == key_idx_t'(NUM_KEYS - 1)) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            key_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            key_q   <= key_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            ready_q <= ready_d;
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            perr_q  <= 1'b0;
            pflag_q <= 1'b0;
        end else begin
            perr_q  <= perr_d;
            pflag_q <= pflag_d;
        end
    end
`endif

    assign key_out    = key_q;
    assign key_sel    = sel_q;
    assign key_enable = en_q;
    assign keys_ready = ready_q;
    assign busy       = state_q == COLLECT;
endmodule

// File: tb/tb_des_key_loader.sv
// tb_des_key_loader: directed checks of key assembly, restart, ignore states and async reset.
module tb_des_key_loader;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic [63:0] key_out;
    logic [1:0]  key_sel;
    logic        key_enable;
    logic        keys_ready;
    logic        busy;
    logic        parity_err;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    logic [63:0] keys [3];

    des_key_loader #(.NUM_KEYS(3)) dut (
        .clk(clk), .n_rst(n_rst), .load_start(load_start), .byte_in(byte_in),
        .byte_valid(byte_valid), .key_out(key_out), .key_sel(key_sel),
        .key_enable(key_enable), .keys_ready(keys_ready), .busy(busy),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_enable) pulses++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ls);
        byte_in = b;
        byte_valid = 1'b1;
        load_start = ls;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic start();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic load_key(input logic [63:0] key, input logic [1:0] sel, input int gap, input logic pub);
        for (int j = 0; j < 8; j++) begin
            send_byte(key[63-8*j -: 8], 1'b0);
            if (j < 7) begin
                chk("en_mid", 64'(key_enable), 64'd0);
                chk("busy_mid", 64'(busy), 64'd1);
            end else begin
                chk("en_pub", 64'(key_enable), 64'(pub));
                if (pub) begin
                    chk("key_out", key_out, key);
                    chk("key_sel", 64'(key_sel), 64'(sel));
                end
            end
            idle(gap);
        end
    endtask

    task automatic full_load(input int gap);
        int p0;
        p0 = pulses;
        start();
        chk("busy_start", 64'(busy), 64'd1);
        chk("ready_clr", 64'(keys_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            load_key(keys[k], 2'(k), gap, 1'b1);
            if (gap == 0 && k == 2) idle(1);
            chk("ready", 64'(keys_ready), 64'(k == 2));
        end
        chk("busy_done", 64'(busy), 64'd0);
        chk("pulses3", 64'(pulses - p0), 64'd3);
    endtask

    initial begin
        int p0;
        keys[0] = 64'h0123456789ABCDEF;
        keys[1] = 64'h23456789ABCDEF01;
        keys[2] = 64'h456789ABCDEF0123;
        #12;
        chk("rst_key", key_out, 64'd0);
        chk("rst_sel", 64'(key_sel), 64'd0);
        chk("rst_en", 64'(key_enable), 64'd0);
        chk("rst_ready", 64'(keys_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_perr", 64'(parity_err), 64'd0);
        n_rst = 1'b1;
        idle(1);

        // Bytes in IDLE are ignored.
        p0 = pulses;
        for (int j = 0; j < 9; j++) send_byte(8'h5A, 1'b0);
        idle(2);
        chk("idle_pulses", 64'(pulses - p0), 64'd0);
        chk("idle_key", key_out, 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        full_load(1);

        // Bytes in DONE are ignored.
        p0 = pulses;
        for (int j = 0; j < 8; j++) send_byte(8'hC3, 1'b0);
        idle(2);
        chk("done_pulses", 64'(pulses - p0), 64'd0);
        chk("done_key", key_out, keys[2]);
        chk("done_ready", 64'(keys_ready), 64'd1);

        full_load(0);

        // Restart mid-key; the coincident 0xAA byte must be dropped.
        p0 = pulses;
        start();
        for (int j = 0; j < 5; j++) send_byte(keys[1][63-8*j -: 8], 1'b0);
        send_byte(8'hAA, 1'b1);
        chk("restart_busy", 64'(busy), 64'd1);
        load_key(keys[0], 2'd0, 1, 1'b1);
        idle(2);
        chk("restart_pulses", 64'(pulses - p0), 64'd1);
        chk("restart_ready", 64'(keys_ready), 64'd0);

`ifdef DES_KEY_PARITY_CHECK_EN
        begin
            logic [63:0] bad;
            bad = keys[0];
            bad[47:40] = 8'h00;
            p0 = pulses;
            start();
            load_key(bad, 2'd0, 1, 1'b0);
            chk("perr_set", 64'(parity_err), 64'd1);
            chk("perr_busy", 64'(busy), 64'd0);
            for (int j = 0; j < 8; j++) send_byte(keys[1][63-8*j -: 8], 1'b0);
            idle(2);
            chk("perr_pulses", 64'(pulses - p0), 64'd0);
            chk("perr_key", key_out, keys[0]);
            start();
            chk("perr_clr", 64'(parity_err), 64'd0);
            load_key(keys[0], 2'd0, 1, 1'b1);
        end
`endif

        // Asynchronous reset mid-transaction.
        start();
        for (int j = 0; j < 4; j++) send_byte(keys[2][63-8*j -: 8], 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_key", key_out, 64'd0);
        chk("arst_sel", 64'(key_sel), 64'd0);
        chk("arst_en", 64'(key_enable), 64'd0);
        chk("arst_ready", 64'(keys_ready), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_perr", 64'(parity_err), 64'd0);
        idle(1);
        n_rst = 1'b1;
        idle(1);
        full_load(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
